strip_read_arbiter: RTL and testbench

- Shares the single read port (port A) of the frame-buffer block RAM between `NUM_STRIPS` independent WS2812 strip drivers.
- Each driver requests bytes by local channel index. The arbiter grants one requester per cycle in round-robin order, translates the local index into a global frame-buffer address, and routes the returned byte back to that requester.
- It sits between the strip drivers and port A. The SPI-slave write path on port B is unaffected.

---
 rtl/ledsuit_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/strip_read_arbiter.sv | 104 ++++++++++
 tb/tb_strip_read_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ledsuit_pkg.sv
// Shared LED-suit constants and frame-buffer layout helpers.
package ledsuit_pkg;

    localparam int unsigned NUM_LEDS     = 160;
    localparam int unsigned NUM_CHANNELS = 3;
    localparam int unsigned STRIP_BYTES  = NUM_LEDS * NUM_CHANNELS;
    localparam int unsigned NUM_STRIPS   = 4;
    localparam int unsigned FB_ADDR_W    = 13;

    // First frame-buffer byte owned by strip i; strips are packed back to back.
    function automatic int unsigned strip_base(int unsigned i, int unsigned bytes = STRIP_BYTES);
        return i * bytes;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer, pointer register.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int unsigned PTR_W = $clog2(N);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_cand;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Search from the pointer with wrap; the first active request wins.
    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = PTR_W'((32'(r_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        // No grants while held in reset.
        if (rst) begin
            w_found = 1'b0;
        end
        o_grant = w_found ? (N'(1) << w_idx) : '0;
    end

    // Pointer moves to just past the granted requester on each accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/strip_read_arbiter.sv
// Shares frame-buffer read port A between strip drivers: arbitration, address
// translation, range check and response routing.
module strip_read_arbiter #(
    parameter int unsigned NUM_STRIPS  = 4,
    parameter int unsigned STRIP_BYTES = 480,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_STRIPS-1:0]        req_valid,
    input  logic [NUM_STRIPS*ADDR_W-1:0] req_addr,
    output logic [NUM_STRIPS-1:0]        req_ready,
    output logic [NUM_STRIPS-1:0]        rsp_valid,
    output logic [7:0]                   rsp_data,
    output logic                         rsp_err,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [7:0]                   mem_dout
);

    import ledsuit_pkg::*;

    localparam int unsigned DEPTH = RAM_LATENCY + 1;

    if (NUM_STRIPS * STRIP_BYTES > 2 ** ADDR_W) begin : g_bad_size
        $error("strip regions do not fit in the frame-buffer address space");
    end
    if (NUM_STRIPS < 2 || NUM_STRIPS > 8) begin : g_bad_strips
        $error("NUM_STRIPS must be 2..8");
    end
    if (RAM_LATENCY < 1 || RAM_LATENCY > 3) begin : g_bad_latency
        $error("RAM_LATENCY must be 1..3");
    end

    logic [NUM_STRIPS-1:0] w_grant;
    logic                  w_hs;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [ADDR_W-1:0]     w_sel_base;
    logic [ADDR_W-1:0]     w_next_addr;
    logic                  w_oor;

    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DEPTH-1:0]      r_vld;
    logic [DEPTH-1:0]      r_err;
    logic [NUM_STRIPS-1:0] r_id [DEPTH];

    assign w_hs      = |(req_valid & w_grant);
    assign req_ready = w_grant;

    rr_arbiter #(
        .N(NUM_STRIPS)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req_valid),
        .i_advance(w_hs),
        .o_grant  (w_grant)
    );

    // Pick the granted strip's local index and its region base.
    always_comb begin
        w_sel_addr = '0;
        w_sel_base = '0;
        for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_base = ADDR_W'(strip_base(i, STRIP_BYTES));
            end
        end
        w_oor       = 32'(w_sel_addr) >= STRIP_BYTES;
        w_next_addr = w_sel_base + w_sel_addr;
    end

    // RAM address register and tag pipeline aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_vld      <= '0;
            r_err      <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_id[k] <= '0;
            end
        end else begin
            // Out-of-range requests leave the RAM address alone.
            if (w_hs && !w_oor) begin
                r_mem_addr <= w_next_addr;
            end
            r_vld[0] <= w_hs;
            r_err[0] <= w_hs & w_oor;
            r_id[0]  <= w_grant;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_err[k] <= r_err[k-1];
                r_id[k]  <= r_id[k-1];
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_vld[DEPTH-1] ? r_id[DEPTH-1] : '0;
    assign rsp_err   = r_vld[DEPTH-1] & r_err[DEPTH-1];
    assign rsp_data  = (r_vld[DEPTH-1] && !r_err[DEPTH-1]) ? mem_dout : 8'h00;

endmodule

// File: tb/tb_strip_read_arbiter.sv
// Directed bench for strip_read_arbiter at RAM latency 1 and 3.
module tb_strip_read_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned SB = 480;
    localparam int unsigned AW = 13;

    logic           clk = 1'b0;
    logic           rst;
    logic [NS-1:0]  req_valid;
    logic [NS*AW-1:0] req_addr;

    logic [NS-1:0]  ready1, rvld1, ready3, rvld3;
    logic [7:0]     rdata1, rdata3, dout1;
    logic           rerr1, rerr3;
    logic [AW-1:0]  maddr1, maddr3;
    logic [7:0]     pipe3 [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Preloaded RAM contents: low byte of the address, high bits folded in.
    function automatic logic [7:0] ram_val(input logic [AW-1:0] a);
        logic [7:0] hi;
        hi = {3'b000, a[12:8]};
        return a[7:0] ^ hi;
    endfunction

    always_ff @(posedge clk) dout1 <= ram_val(maddr1);

    always_ff @(posedge clk) begin
        pipe3[0] <= ram_val(maddr3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    strip_read_arbiter #(
        .NUM_STRIPS(NS), .STRIP_BYTES(SB), .ADDR_W(AW), .RAM_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rsp_valid(rvld1), .rsp_data(rdata1), .rsp_err(rerr1),
        .mem_addr(maddr1), .mem_dout(dout1)
    );

    strip_read_arbiter #(
        .NUM_STRIPS(NS), .STRIP_BYTES(SB), .ADDR_W(AW), .RAM_LATENCY(3)
    ) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready3), .rsp_valid(rvld3), .rsp_data(rdata3), .rsp_err(rerr3),
        .mem_addr(maddr3), .mem_dout(pipe3[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NS-1:0] rv, input logic [AW-1:0] la);
        req_valid = rv;
        for (int i = 0; i < NS; i++) req_addr[i*AW +: AW] = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NS-1:0] rv;
        logic [AW-1:0] la;
        logic [NS-1:0] ready;
        logic [AW-1:0] maddr;
        logic [NS-1:0] rvld;
        logic [7:0]    rdata;
        logic          rerr;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // One entry per cycle from reset release; rsp columns refer to grants two cycles back.
        vecs[0]  = '{4'b1111, 13'd5,   4'b0001, 13'd0,    4'b0000, 8'h00, 1'b0};
        vecs[1]  = '{4'b1111, 13'd5,   4'b0010, 13'd5,    4'b0000, 8'h00, 1'b0};
        vecs[2]  = '{4'b1111, 13'd5,   4'b0100, 13'd485,  4'b0001, 8'h05, 1'b0};
        vecs[3]  = '{4'b1111, 13'd5,   4'b1000, 13'd965,  4'b0010, 8'hE4, 1'b0};
        vecs[4]  = '{4'b1111, 13'd5,   4'b0001, 13'd1445, 4'b0100, 8'hC6, 1'b0};
        vecs[5]  = '{4'b1010, 13'd7,   4'b0010, 13'd5,    4'b1000, 8'hA0, 1'b0};
        vecs[6]  = '{4'b1010, 13'd7,   4'b1000, 13'd487,  4'b0001, 8'h05, 1'b0};
        vecs[7]  = '{4'b1010, 13'd7,   4'b0010, 13'd1447, 4'b0010, 8'hE6, 1'b0};
        vecs[8]  = '{4'b0100, 13'd480, 4'b0100, 13'd487,  4'b1000, 8'hA2, 1'b0};
        vecs[9]  = '{4'b0000, 13'd0,   4'b0000, 13'd487,  4'b0010, 8'hE6, 1'b0};
        vecs[10] = '{4'b0000, 13'd0,   4'b0000, 13'd487,  4'b0100, 8'h00, 1'b1};
        vecs[11] = '{4'b0000, 13'd0,   4'b0000, 13'd487,  4'b0000, 8'h00, 1'b0};
        vecs[12] = '{4'b0001, 13'd479, 4'b0001, 13'd487,  4'b0000, 8'h00, 1'b0};
        vecs[13] = '{4'b0100, 13'd479, 4'b0100, 13'd479,  4'b0000, 8'h00, 1'b0};
        vecs[14] = '{4'b0000, 13'd0,   4'b0000, 13'd1439, 4'b0001, 8'hDE, 1'b0};
        vecs[15] = '{4'b0000, 13'd0,   4'b0000, 13'd1439, 4'b0100, 8'h9A, 1'b0};
        vecs[16] = '{4'b0000, 13'd0,   4'b0000, 13'd1439, 4'b0000, 8'h00, 1'b0};

        // Reset state, with requests already asserted.
        rst = 1'b1;
        drive(4'b1111, 13'd5);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_ready", 32'(ready1), 32'h0);
        check("reset_mem_addr", 32'(maddr1), 32'h0);
        check("reset_rsp_valid", 32'(rvld1), 32'h0);
        check("reset_rsp_data", 32'(rdata1), 32'h0);
        check("reset_rsp_err", 32'(rerr1), 32'h0);
        next_cycle();
        rst = 1'b0;

        // Table: all-four round robin, fairness, out-of-range, boundary index.
        for (int v = 0; v < 17; v++) begin
            drive(vecs[v].rv, vecs[v].la);
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), 32'(ready1), 32'(vecs[v].ready));
            check($sformatf("vec%0d_mem_addr", v), 32'(maddr1), 32'(vecs[v].maddr));
            check($sformatf("vec%0d_rsp_valid", v), 32'(rvld1), 32'(vecs[v].rvld));
            check($sformatf("vec%0d_rsp_data", v), 32'(rdata1), 32'(vecs[v].rdata));
            check($sformatf("vec%0d_rsp_err", v), 32'(rerr1), 32'(vecs[v].rerr));
            next_cycle();
        end

        // Single requester back-to-back: eight responses with no bubble.
        for (int c = 0; c < 10; c++) begin
            drive((c < 8) ? 4'b0001 : 4'b0000, AW'(c));
            @(negedge clk);
            if (c < 8) check($sformatf("b2b%0d_ready", c), 32'(ready1), 32'h1);
            check($sformatf("b2b%0d_rsp_valid", c), 32'(rvld1), (c >= 2) ? 32'h1 : 32'h0);
            check($sformatf("b2b%0d_rsp_data", c), 32'(rdata1), (c >= 2) ? 32'(c - 2) : 32'h0);
            next_cycle();
        end

        // Reset mid-flight: grant strip 1, then reset; no response may follow.
        drive(4'b0000, 13'd0);
        next_cycle();
        drive(4'b0010, 13'd9);
        @(negedge clk);
        check("mid_ready", 32'(ready1), 32'h2);
        next_cycle();
        drive(4'b0000, 13'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_mem_addr_pre", 32'(maddr1), 32'd489);
        check("mid_ready_in_rst", 32'(ready1), 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("mid%0d_rsp_valid", c), 32'(rvld1), 32'h0);
            check($sformatf("mid%0d_rsp_valid3", c), 32'(rvld3), 32'h0);
            check($sformatf("mid%0d_mem_addr", c), 32'(maddr1), 32'h0);
            next_cycle();
        end
        drive(4'b1111, 13'd0);
        @(negedge clk);
        check("mid_after_ready", 32'(ready1), 32'h1);
        next_cycle();
        drive(4'b0000, 13'd0);
        repeat (6) next_cycle();

        // Latency 3: alternating strips 0/1, responses four cycles after grant.
        for (int c = 0; c < 12; c++) begin
            if (c < 6) drive(4'(1 << (c % 2)), AW'(10 + c));
            else drive(4'b0000, 13'd0);
            @(negedge clk);
            if (c < 6) check($sformatf("l3_%0d_ready", c), 32'(ready3), 32'(1 << (c % 2)));
            if (c >= 1 && c <= 6)
                check($sformatf("l3_%0d_mem_addr", c), 32'(maddr3),
                      ((c - 1) % 2) * SB + 10 + (c - 1));
            if (c >= 4 && c < 10) begin
                check($sformatf("l3_%0d_rsp_valid", c), 32'(rvld3), 32'(1 << ((c - 4) % 2)));
                check($sformatf("l3_%0d_rsp_data", c), 32'(rdata3),
                      32'(ram_val(AW'(((c - 4) % 2) * SB + 10 + (c - 4)))));
            end else begin
                check($sformatf("l3_%0d_rsp_valid", c), 32'(rvld3), 32'h0);
                check($sformatf("l3_%0d_rsp_data", c), 32'(rdata3), 32'h0);
            end
            check($sformatf("l3_%0d_rsp_err", c), 32'(rerr3), 32'h0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
